// File: rtl/bus_master_ctrl_pkg.sv
// rtl/bus_master_ctrl_pkg.sv - shared constants and state encoding for the bus initiator
package bus_master_ctrl_pkg;

    // Bus direction values on rw / req_rw
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    // Active-low strobe levels for cs_ / as_
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int BM_STATE_W = 1;

    typedef enum logic [BM_STATE_W-1:0] {
        BM_STATE_IDLE   = 1'b0,
        BM_STATE_ACCESS = 1'b1
    } bm_state_e;

endpackage

// File: rtl/bus_timeout_cnt.sv
// rtl/bus_timeout_cnt.sv - saturating access-cycle counter with timeout expiry flag
module bus_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    // Value the counter holds during the last permitted waiting cycle
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? CNT_MAX : CNT_W'(TIMEOUT - 1);
    localparam logic             TMO_ON   = (TIMEOUT != 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority; counting stops at all-ones so the value never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = TMO_ON && (cnt_q == CNT_LAST);

endmodule

// File: rtl/bus_master_ctrl.sv
// rtl/bus_master_ctrl.sv - single-word bus initiator with rdy_ handshake and timeout
import bus_master_ctrl_pkg::*;

module bus_master_ctrl #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rd_data_out,
    output logic              cs_,
    output logic              as_,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rdy_
);

    bm_state_e         state_q, state_d;
    logic              cs_q, cs_d;
    logic              as_q, as_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              tmo_clr;
    logic              tmo_en;
    logic              tmo_expire;

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    // Next-state and next-output logic; rdy_ wins over timeout in the same cycle
    always_comb begin
        state_d   = state_q;
        cs_d      = cs_q;
        as_d      = as_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        case (state_q)
            BM_STATE_IDLE: begin
                cs_d   = DISABLE_;
                as_d   = DISABLE_;
                busy_d = 1'b0;
                if (req) begin
                    rw_d      = req_rw;
                    addr_d    = req_addr;
                    wr_data_d = req_wr_data;
                    cs_d      = ENABLE_;
                    as_d      = ENABLE_;
                    busy_d    = 1'b1;
                    tmo_clr   = 1'b1;
                    state_d   = BM_STATE_ACCESS;
                end
            end
            BM_STATE_ACCESS: begin
                if (rdy_ == ENABLE_) begin
                    if (rw_q == READ) begin
                        rd_data_d = rd_data;
                    end
                    cs_d    = DISABLE_;
                    as_d    = DISABLE_;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = BM_STATE_IDLE;
                end else if (tmo_expire) begin
                    cs_d    = DISABLE_;
                    as_d    = DISABLE_;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = BM_STATE_IDLE;
                end else begin
                    tmo_en  = 1'b1;
                end
            end
            default: begin
                state_d = BM_STATE_IDLE;
            end
        endcase
    end

    // State and registered bus/core outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BM_STATE_IDLE;
            cs_q      <= DISABLE_;
            as_q      <= DISABLE_;
            rw_q      <= READ;
            addr_q    <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cs_q      <= cs_d;
            as_q      <= as_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign cs_         = cs_q;
    assign as_         = as_q;
    assign rw          = rw_q;
    assign addr        = addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rd_data_out = rd_data_q;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// tb/tb_bus_master_ctrl.sv - randomized self-checking bench for bus_master_ctrl
import bus_master_ctrl_pkg::*;

module tb_bus_master_ctrl;

    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              req;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rd_data_out;
    logic              cs_;
    logic              as_;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data = '0;
    logic              rdy_    = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bus_master_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rd_data_out (rd_data_out),
        .cs_         (cs_),
        .as_         (as_),
        .rw          (rw),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .rdy_        (rdy_)
    );

    // Gpio-like responder: answers resp_lat cycles after seeing cs_ low
    logic [DATA_W-1:0] resp_mem [4];
    int                resp_lat     = 1;
    int                resp_cnt     = 0;
    bit                idle_rdy_low = 1'b0;

    always @(negedge clk) begin
        if (reset === 1'b1 || cs_ !== 1'b0) begin
            resp_cnt = 0;
            rdy_     = idle_rdy_low ? 1'b0 : 1'b1;
        end else begin
            resp_cnt = resp_cnt + 1;
            if (resp_cnt == resp_lat) begin
                rdy_ = 1'b0;
                if (rw == READ) rd_data = resp_mem[addr[1:0]];
                else            resp_mem[addr[1:0]] = wr_data;
            end else begin
                rdy_    = 1'b1;
                rd_data = $urandom;
            end
        end
    end

    // Reference model: memory image and last successfully read word
    logic [DATA_W-1:0] ref_mem [4];
    logic [DATA_W-1:0] exp_rd = '0;

    task automatic do_xfer(input logic rw_i, input logic [1:0] a, input logic [DATA_W-1:0] d,
                           input int lat, input string tag);
        bit                ok      = (lat <= TIMEOUT);
        int                exp_cyc = ok ? lat : TIMEOUT;
        int                cyc     = 0;
        bit                bad     = 1'b0;
        logic [ADDR_W-1:0] a_full  = ADDR_W'(a);
        resp_lat = lat;
        @(negedge clk);
        req = 1'b1; req_rw = rw_i; req_addr = a_full; req_wr_data = d;
        @(negedge clk);
        req = 1'b0; req_rw = 1'($urandom); req_addr = ADDR_W'($urandom); req_wr_data = $urandom;
        while (cs_ === 1'b0 && cyc < 40) begin
            if (as_ !== 1'b0 || rw !== rw_i || addr !== a_full || wr_data !== d ||
                busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) bad = 1'b1;
            cyc++;
            @(negedge clk);
        end
        if (ok) begin
            if (rw_i == READ) exp_rd = ref_mem[a];
            else              ref_mem[a] = d;
        end
        n_cmp++;
        if (bad) begin
            n_fail++; $display("FAIL %s access_stable: got unstable bus/status during access, expected stable", tag);
        end
        n_cmp++;
        if (cyc !== exp_cyc) begin
            n_fail++; $display("FAIL %s access_cycles: got %0d expected %0d", tag, cyc, exp_cyc);
        end
        n_cmp++;
        if ({done, err, busy, cs_, as_} !== {ok, !ok, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL %s end_status: got done=%b err=%b busy=%b cs_=%b as_=%b expected done=%b err=%b busy=0 cs_=1 as_=1",
                     tag, done, err, busy, cs_, as_, ok, !ok);
        end
        n_cmp++;
        if (rd_data_out !== exp_rd) begin
            n_fail++; $display("FAIL %s rd_data_out: got %h expected %h", tag, rd_data_out, exp_rd);
        end
        n_cmp++;
        if (rw !== rw_i || addr !== a_full || wr_data !== d) begin
            n_fail++; $display("FAIL %s hold: got rw=%b addr=%h wr_data=%h expected rw=%b addr=%h wr_data=%h",
                               tag, rw, addr, wr_data, rw_i, a_full, d);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || err !== 1'b0 || cs_ !== 1'b1) begin
            n_fail++; $display("FAIL %s pulse_width: got done=%b err=%b cs_=%b expected 0 0 1", tag, done, err, cs_);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; req_rw = WRITE; req_addr = '0; req_wr_data = '0;
        #3;
        n_cmp++;
        if ({cs_, as_, rw, busy, done, err} !== {1'b1, 1'b1, READ, 3'b000} ||
            addr !== '0 || wr_data !== '0 || rd_data_out !== '0) begin
            n_fail++; $display("FAIL reset_values: got cs_=%b as_=%b rw=%b busy=%b done=%b err=%b addr=%h wr=%h rd=%h",
                               cs_, as_, rw, busy, done, err, addr, wr_data, rd_data_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_rdy_ignored();
        bit bad = 1'b0;
        idle_rdy_low = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || cs_ !== 1'b1) bad = 1'b1;
        end
        idle_rdy_low = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bad) begin
            n_fail++; $display("FAIL rdy_in_idle: got activity with rdy_ low in idle, expected none");
        end
    endtask

    task automatic test_read();
        resp_mem[0] = 32'h0000_000a; ref_mem[0] = 32'h0000_000a;
        do_xfer(READ, 2'd0, $urandom, 1, "read_gpio");
    endtask

    task automatic test_write();
        do_xfer(WRITE, 2'd1, 32'h56, 1, "write_gpio");
        n_cmp++;
        if (resp_mem[1] !== 32'h56) begin
            n_fail++; $display("FAIL write_gpio_out: got %h expected %h", resp_mem[1], 32'h56);
        end
    endtask

    task automatic test_timeout();
        do_xfer(READ,  2'd1, $urandom, TIMEOUT,     "lat_at_limit");
        do_xfer(READ,  2'd1, $urandom, TIMEOUT + 1, "lat_over_limit");
        do_xfer(WRITE, 2'd2, $urandom, 1000,        "hung_responder");
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        resp_lat = 2;
        @(negedge clk);
        req = 1'b1; req_rw = WRITE; req_addr = ADDR_W'(2); req_wr_data = 32'h59;
        while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        ref_mem[2] = 32'h59;
        n_cmp++;
        if (done !== 1'b1 || cs_ !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first_done: got done=%b cs_=%b expected 1 1", done, cs_);
        end
        req_rw = READ;
        @(negedge clk);
        n_cmp++;
        if (cs_ !== 1'b0 || rw !== READ || busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second_accept: got cs_=%b rw=%b busy=%b expected 0 1 1", cs_, rw, busy);
        end
        req = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        exp_rd = ref_mem[2];
        n_cmp++;
        if (done !== 1'b1 || rd_data_out !== exp_rd) begin
            n_fail++; $display("FAIL b2b_read_back: got done=%b rd=%h expected 1 %h", done, rd_data_out, exp_rd);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignored();
        int cyc = 0;
        logic [DATA_W-1:0] d = $urandom;
        resp_lat = 5;
        @(negedge clk);
        req = 1'b1; req_rw = WRITE; req_addr = ADDR_W'(3); req_wr_data = d;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        req = 1'b1; req_rw = READ; req_addr = ADDR_W'(0); req_wr_data = ~d;
        @(negedge clk);
        req = 1'b0;
        while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        ref_mem[3] = d;
        n_cmp++;
        if (done !== 1'b1 || rw !== WRITE || addr !== ADDR_W'(3) || wr_data !== d || resp_mem[3] !== d) begin
            n_fail++; $display("FAIL busy_req_ignored: got done=%b rw=%b addr=%h wr=%h expected 1 0 3 %h",
                               done, rw, addr, wr_data, d);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (cs_ !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_no_queue: got cs_=%b busy=%b expected 1 0", cs_, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        resp_lat = 1000;
        @(negedge clk);
        req = 1'b1; req_rw = READ; req_addr = ADDR_W'(1); req_wr_data = $urandom;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        exp_rd = '0;
        n_cmp++;
        if (cs_ !== 1'b1 || as_ !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            rd_data_out !== '0 || addr !== '0 || rw !== READ) begin
            n_fail++; $display("FAIL reset_mid: got cs_=%b busy=%b done=%b err=%b rd=%h addr=%h expected 1 0 0 0 0 0",
                               cs_, busy, done, err, rd_data_out, addr);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || err !== 1'b0 || cs_ !== 1'b1) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_fail++; $display("FAIL reset_no_pulse: got done/err/strobe activity after reset, expected none");
        end
        do_xfer(READ, 2'd0, $urandom, 2, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            do_xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(1, TIMEOUT + 3), "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            resp_mem[i] = $urandom;
            ref_mem[i]  = resp_mem[i];
        end
        test_reset();
        test_rdy_ignored();
        test_read();
        test_write();
        test_timeout();
        test_back_to_back();
        test_busy_ignored();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion within time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
